// File: rtl/mc10_ram_scheduler.sv
// Four-slot scheduler sharing one single-port 4Kx8 RAM between the VDG, the CPU and a FIFO-fed loader.
// Define MC10_SCHED_CPU_HOLD_EN to stall the CPU (no cpu_ce) for the whole duration of a download.
module mc10_ram_scheduler #(
  parameter int ADDR_W     = 12,
  parameter int LOAD_DEPTH = 4
) (
  input  logic              clk_4,
  input  logic              RESET,
  output logic              cpu_ce,
  input  logic              cpu_sel,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              vdg_req,
  input  logic [ADDR_W-1:0] vdg_addr,
  output logic [7:0]        vdg_dout,
  output logic              vdg_valid,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  output logic              ram_we,
  input  logic [7:0]        ram_q
);

  localparam int PTR_W = $clog2(LOAD_DEPTH);
  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(LOAD_DEPTH);

  typedef enum logic [1:0] {
    SLOT_VDG = 2'd0,
    SLOT_LD1 = 2'd1,
    SLOT_CPU = 2'd2,
    SLOT_LD3 = 2'd3
  } slot_e;

  slot_e r_slot;
  slot_e w_slot_next;

  logic [ADDR_W+7:0] r_fifo [LOAD_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic              r_pend;
  logic [ADDR_W-1:0] r_pend_addr;
  logic              r_vdg_rd;
  logic              r_cpu_rd;
  logic              r_vdg_valid;
  logic [7:0]        r_vdg_dout;
  logic [7:0]        r_cpu_dout;
  logic              r_cpu_ce;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [7:0]        r_ram_din;
  logic              r_ram_we;

  logic              w_busy;
  logic              w_full;
  logic              w_push;
  logic              w_hold;
  logic              w_vdg_go;
  logic              w_cpu_go;
  logic              w_pop;
  logic [ADDR_W-1:0] w_head_addr;
  logic [7:0]        w_head_data;

  assign w_busy = (r_count != '0);
  assign w_full = (r_count == C_FULL);
  assign w_push = ld_valid && !w_full;
  assign {w_head_addr, w_head_data} = r_fifo[r_rd_ptr];

`ifdef MC10_SCHED_CPU_HOLD_EN
  assign w_hold = w_busy || ld_valid;
`else
  assign w_hold = 1'b0;
`endif

  // Slot counter: state register.
  always_ff @(posedge clk_4 or posedge RESET) begin
    if (RESET) r_slot <= SLOT_VDG;
    else       r_slot <= w_slot_next;
  end

  always_comb begin
    w_slot_next = slot_e'(r_slot + 2'd1);
  end

  // Slot owner decode; every slot the VDG or CPU leaves unused falls to the loader.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_vdg_go = 1'b0;
    w_cpu_go = 1'b0;
    if (r_slot == SLOT_VDG) w_vdg_go = r_pend;
    if (r_slot == SLOT_CPU) w_cpu_go = cpu_sel && !w_hold;
    w_pop = !w_vdg_go && !w_cpu_go && w_busy;
  end

  // NOTE: FIFO storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk_4) begin
    if (w_push) r_fifo[r_wr_ptr] <= {ld_addr, ld_data};
  end

  always_ff @(posedge clk_4 or posedge RESET) begin
    if (RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // A request in the same cycle as the issue re-arms pending, so the latest address is never lost.
  always_ff @(posedge clk_4 or posedge RESET) begin
    if (RESET) begin
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
    end else if (vdg_req) begin
      r_pend      <= 1'b1;
      r_pend_addr <= vdg_addr;
    end else if (w_vdg_go) begin
      r_pend      <= 1'b0;
    end
  end

  always_ff @(posedge clk_4 or posedge RESET) begin
    if (RESET) begin
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_ram_we    <= 1'b0;
      r_vdg_rd    <= 1'b0;
      r_cpu_rd    <= 1'b0;
      r_vdg_valid <= 1'b0;
      r_vdg_dout  <= '0;
      r_cpu_dout  <= '0;
      r_cpu_ce    <= 1'b0;
    end else begin
      r_ram_we    <= (w_cpu_go && !cpu_rw) || w_pop;
      r_vdg_rd    <= w_vdg_go;
      r_cpu_rd    <= w_cpu_go && cpu_rw;
      r_vdg_valid <= r_vdg_rd;
      r_cpu_ce    <= (r_slot == SLOT_CPU) && !w_hold;
      if (w_vdg_go) begin
        r_ram_addr <= r_pend_addr;
      end else if (w_cpu_go) begin
        r_ram_addr <= cpu_addr;
        r_ram_din  <= cpu_din;
      end else if (w_pop) begin
        r_ram_addr <= w_head_addr;
        r_ram_din  <= w_head_data;
      end
      // Read data is on ram_q the slot after the issue: slot 1 for the VDG, slot 3 for the CPU.
      if (r_vdg_rd) r_vdg_dout <= ram_q;
      if (r_cpu_rd) r_cpu_dout <= ram_q;
    end
  end

  assign cpu_ce    = r_cpu_ce;
  assign cpu_dout  = r_cpu_dout;
  assign vdg_dout  = r_vdg_dout;
  assign vdg_valid = r_vdg_valid;
  assign ld_ready  = !w_full;
  assign ld_busy   = w_busy;
  assign ram_addr  = r_ram_addr;
  assign ram_din   = r_ram_din;
  assign ram_we    = r_ram_we;

endmodule

// File: tb/tb_mc10_ram_scheduler.sv
// Directed bench for mc10_ram_scheduler with a behavioural 4Kx8 RAM (registered address in the DUT).
// Expectations follow MC10_SCHED_CPU_HOLD_EN when the bench is compiled with it.
module tb_mc10_ram_scheduler;

`ifdef MC10_SCHED_CPU_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk_4 = 1'b0;
  logic        RESET = 1'b1;
  logic        cpu_ce;
  logic        cpu_sel = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        vdg_req = 1'b0;
  logic [11:0] vdg_addr = '0;
  logic [7:0]  vdg_dout;
  logic        vdg_valid;
  logic        ld_valid = 1'b0;
  logic [11:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        ld_ready;
  logic        ld_busy;
  logic [11:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_q;

  typedef struct packed {
    logic [11:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0] mem [4096];
  wr_t        wlog[$];
  int         n_checks = 0;
  int         n_err = 0;
  logic [1:0] tb_slot = 2'd0;
  logic [1:0] slot_before;
  int         n_exp;

  mc10_ram_scheduler #(.ADDR_W(12), .LOAD_DEPTH(4)) dut (
    .clk_4(clk_4), .RESET(RESET), .cpu_ce(cpu_ce), .cpu_sel(cpu_sel), .cpu_rw(cpu_rw),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout), .vdg_req(vdg_req),
    .vdg_addr(vdg_addr), .vdg_dout(vdg_dout), .vdg_valid(vdg_valid), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk_4 = ~clk_4;

  // The RAM's address register is ram_addr itself, so read data follows it within the cycle.
  assign ram_q = mem[ram_addr];

  always @(posedge clk_4) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wlog.push_back(wr_t'{ram_addr, ram_din});
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_4);
    #1;
    tb_slot = tb_slot + 2'd1;
  endtask

  task automatic step_to(input logic [1:0] k);
    tick();
    while (tb_slot != k) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ce"},    cpu_ce,    1'b0);
    check({tag, "_we"},    ram_we,    1'b0);
    check({tag, "_addr"},  ram_addr,  12'h000);
    check({tag, "_din"},   ram_din,   8'h00);
    check({tag, "_rdy"},   ld_ready,  1'b1);
    check({tag, "_busy"},  ld_busy,   1'b0);
    check({tag, "_cdout"}, cpu_dout,  8'h00);
    check({tag, "_vdout"}, vdg_dout,  8'h00);
    check({tag, "_vval"},  vdg_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    #0;
    mem[12'h123] <= 8'hA5;
    mem[12'h040] <= 8'h3C;
    mem[12'h050] <= 8'h99;

    // Reset state, then release between edges so the next edge enters slot 1.
    repeat (3) @(posedge clk_4);
    #1;
    check_reset_outputs("rst");
    #1;
    RESET = 1'b0;
    tb_slot = 2'd0;

    // Idle: cpu_ce only in slot 3, no RAM writes.
    for (int i = 0; i < 8; i++) begin
      tick();
      check("idle_ce", cpu_ce, tb_slot == 2'd3);
      check("idle_we", ram_we, 1'b0);
    end
    check("idle_rdy", ld_ready, 1'b1);

    // CPU read of the preloaded byte.
    step_to(2'd2);
    cpu_sel = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h123;
    tick();
    check("crd_addr", ram_addr, 12'h123);
    check("crd_we", ram_we, 1'b0);
    check("crd_ce", cpu_ce, 1'b1);
    cpu_sel = 1'b0;
    tick();
    check("crd_dout", cpu_dout, 8'hA5);

    // CPU write: RAM updated, cpu_dout held.
    step_to(2'd2);
    cpu_sel = 1'b1; cpu_rw = 1'b0; cpu_addr = 12'h300; cpu_din = 8'h77;
    tick();
    check("cwr_we", ram_we, 1'b1);
    check("cwr_addr", ram_addr, 12'h300);
    check("cwr_din", ram_din, 8'h77);
    cpu_sel = 1'b0; cpu_rw = 1'b1;
    tick();
    check("cwr_mem", mem[12'h300], 8'h77);
    check("cwr_dout", cpu_dout, 8'hA5);

    // Single VDG fetch requested in slot 2.
    step_to(2'd2);
    vdg_req = 1'b1; vdg_addr = 12'h040;
    tick();
    vdg_req = 1'b0;
    check("v1_val3", vdg_valid, 1'b0);
    tick();
    tick();
    check("v1_addr", ram_addr, 12'h040);
    check("v1_val1", vdg_valid, 1'b0);
    tick();
    check("v1_val", vdg_valid, 1'b1);
    check("v1_dout", vdg_dout, 8'h3C);
    tick();
    check("v1_pulse", vdg_valid, 1'b0);

    // Two requests in one round: the latest address wins, one fetch only.
    step_to(2'd1);
    vdg_req = 1'b1; vdg_addr = 12'h040;
    tick();
    vdg_addr = 12'h050;
    tick();
    vdg_req = 1'b0;
    step_to(2'd1);
    check("v2_addr", ram_addr, 12'h050);
    tick();
    check("v2_val", vdg_valid, 1'b1);
    check("v2_dout", vdg_dout, 8'h99);
    step_to(2'd2);
    check("v2_once", vdg_valid, 1'b0);

    // Request in slot 0 is served in the next round's slot 0.
    step_to(2'd0);
    vdg_req = 1'b1; vdg_addr = 12'h040;
    tick();
    vdg_req = 1'b0;
    tick();
    check("v0_late", vdg_valid, 1'b0);
    step_to(2'd1);
    check("v0_addr", ram_addr, 12'h040);
    tick();
    check("v0_val", vdg_valid, 1'b1);
    check("v0_dout", vdg_dout, 8'h3C);

    // Loader: 4 back-to-back pushes with the CPU idle.
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = 12'h200 + 12'(i); ld_data = 8'(8'h11 * (i + 1));
      slot_before = tb_slot;
      tick();
      check("ld_busy", ld_busy, 1'b1);
      check("ld_rdy", ld_ready, 1'b1);
      check("ld_ce", cpu_ce, (slot_before == 2'd2) && !HOLD);
    end
    ld_valid = 1'b0;
    slot_before = tb_slot;
    tick();
    check("ld_drain", ld_busy, 1'b0);
    check("ld_ce_d", cpu_ce, (slot_before == 2'd2) && !HOLD);
    for (int i = 0; i < 8; i++) begin
      slot_before = tb_slot;
      tick();
      check("ld_ce_r", cpu_ce, slot_before == 2'd2);
    end
    check("ld_nwr", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      check("ld_wa", wlog[i].a, 12'h200 + 12'(i));
      check("ld_wd", wlog[i].d, 8'(8'h11 * (i + 1)));
    end
    check("ld_mem", mem[12'h203], 8'h44);

    // Fill: CPU and VDG own slots 2 and 0, so the FIFO only drains in slots 1 and 3.
    wlog.delete();
    cpu_sel = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h123;
    vdg_req = 1'b1; vdg_addr = 12'h040;
    step_to(2'd2);
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1; ld_addr = 12'h210 + 12'(i); ld_data = 8'h80 + 8'(i);
      tick();
      if (i == 5) check("fill_rdy6", ld_ready, 1'b1);
    end
    check("fill_full", ld_ready, HOLD);
    ld_addr = 12'h217; ld_data = 8'h87;
    tick();
    ld_valid = 1'b0; cpu_sel = 1'b0; vdg_req = 1'b0;
    repeat (12) tick();
    check("fill_busy", ld_busy, 1'b0);
    n_exp = HOLD ? 8 : 7;
    check("fill_nwr", wlog.size(), n_exp);
    for (int i = 0; i < n_exp && i < wlog.size(); i++) begin
      check("fill_wa", wlog[i].a, 12'h210 + 12'(i));
      check("fill_wd", wlog[i].d, 8'h80 + 8'(i));
    end

    // Reset mid-operation with queued entries and a pending VDG request.
    cpu_sel = 1'b1; cpu_rw = 1'b1; cpu_addr = 12'h123;
    vdg_req = 1'b1; vdg_addr = 12'h040;
    step_to(2'd2);
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_addr = 12'h220 + 12'(i); ld_data = 8'hC0 + 8'(i);
      tick();
    end
    check("pre_busy", ld_busy, 1'b1);
    ld_valid = 1'b0; cpu_sel = 1'b0; vdg_req = 1'b0;
    #1;
    RESET = 1'b1;
    wlog.delete();
    #1;
    check_reset_outputs("mid");
    repeat (3) @(posedge clk_4);
    #2;
    RESET = 1'b0;
    tb_slot = 2'd0;
    check("mid_nwr", wlog.size(), 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_ce", cpu_ce, tb_slot == 2'd3);
      check("post_we", ram_we, 1'b0);
      check("post_vval", vdg_valid, 1'b0);
      check("post_busy", ld_busy, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
